fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_pkg.sv | 5 +
 rtl/stream_skid2.sv | 41 ++++
 rtl/fifo_stream_reader.sv | 96 +++++++++
 tb/tb_fifo_stream_reader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared reader state type and default data width
package fifo_pkg;
  localparam int FIFO_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} rd_state_e;
endpackage

// File: rtl/stream_skid2.sv
// stream_skid2: 2-entry in-order output buffer with valid/ready drain and occupancy
module stream_skid2
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             m_ready_i,
  output logic             m_valid_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic [1:0]       occ_o
);
  logic [WIDTH-1:0] d0_q, d0_d, d1_q, d1_d;
  logic [1:0] occ_q, occ_d, slot;
  logic pop;
  always_ff @(posedge clk) begin
    if (!rst) begin
      d0_q  <= '0;
      d1_q  <= '0;
      occ_q <= '0;
    end else begin
      d0_q  <= d0_d;
      d1_q  <= d1_d;
      occ_q <= occ_d;
    end
  end
  // Incoming word lands in the slot left free after this cycle's pop
  always_comb begin
    pop   = m_valid_o && m_ready_i;
    slot  = occ_q - 2'(pop);
    occ_d = occ_q + 2'(in_valid_i) - 2'(pop);
    d0_d  = (in_valid_i && slot == 2'd0) ? in_data_i : pop ? d1_q : d0_q;
    d1_d  = (in_valid_i && slot == 2'd1) ? in_data_i : d1_q;
  end
  assign m_valid_o = occ_q != 2'd0;
  assign m_data_o  = d0_q;
  assign occ_o     = occ_q;
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: bursts words from a FIFO into a 2-deep valid/ready output stream
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic             rd_en,
  input  logic [WIDTH-1:0] rdata,
  input  logic             empty_flag,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             abort,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [LEN_W-1:0] word_count
);
  localparam logic [LEN_W:0] REM_ONE = (LEN_W+1)'(1);
  localparam logic [LEN_W:0] REM_MAX = REM_ONE << LEN_W;
  rd_state_e state_q, state_d;
  logic [LEN_W:0] rem_q, rem_d;
  logic [LEN_W-1:0] wc_q, wc_d;
  logic infl_q, aborted_q, aborted_d, done_q, done_d, pop;
  logic [1:0] occ;
  stream_skid2 #(.WIDTH(WIDTH)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid_i(infl_q),
    .in_data_i (rdata),
    .m_ready_i (m_ready),
    .m_valid_o (m_valid),
    .m_data_o  (m_data),
    .occ_o     (occ)
  );
  assign pop = m_valid && m_ready;
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      rem_q     <= '0;
      wc_q      <= '0;
      infl_q    <= 1'b0;
      aborted_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rem_q     <= rem_d;
      wc_q      <= wc_d;
      infl_q    <= rd_en;
      aborted_q <= aborted_d;
      done_q    <= done_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    rem_d     = rd_en ? rem_q - REM_ONE : rem_q;
    wc_d      = pop ? wc_q + LEN_W'(1) : wc_q;
    aborted_d = aborted_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d   = RUN;
        rem_d     = burst_len == '0 ? REM_MAX : {1'b0, burst_len};
        wc_d      = '0;
        aborted_d = 1'b0;
      end
      RUN: if (abort) begin
        state_d   = FLUSH;
        aborted_d = 1'b1;
      end else if (rd_en && rem_q == REM_ONE) begin
        state_d = FLUSH;
      end
      FLUSH: if (!infl_q && occ == {1'b0, pop}) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // Read only while buffer plus in-flight, after this cycle's pop, leaves room
  always_comb begin
    busy       = state_q != IDLE;
    rd_en      = rst && state_q == RUN && rem_q != '0 && !empty_flag && !abort &&
                 (3'(occ) + 3'(infl_q) - 3'(pop)) < 3'd2;
    done       = done_q;
    aborted    = aborted_q;
    word_count = wc_q;
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: randomized scenarios against a queue-based FIFO and expected-stream model
module tb_fifo_stream_reader;
  localparam int W = 32;
  localparam int L = 8;
  logic clk = 1'b0, rst = 1'b0, rd_en, empty_flag = 1'b1, start = 1'b0, abort = 1'b0;
  logic m_valid, m_ready = 1'b0, busy, done, aborted;
  logic [W-1:0] rdata = '0, m_data, held = '0;
  logic [L-1:0] burst_len = '0, word_count;
  logic [W-1:0] fifo_q[$], exp_q[$];
  int checks = 0, passes = 0, cyc = 0, accepted = 0, xfers = 0, dones = 0;
  int done_cyc = -1, first_x = -1, last_x = -1;
  bit force_empty = 0, stalled = 0;

  always #5 clk = ~clk;

  fifo_stream_reader #(.WIDTH(W), .LEN_W(L)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rdata(rdata), .empty_flag(empty_flag),
    .start(start), .burst_len(burst_len), .abort(abort), .m_valid(m_valid),
    .m_data(m_data), .m_ready(m_ready), .busy(busy), .done(done),
    .aborted(aborted), .word_count(word_count)
  );

  // One clock: drive inputs, observe the stream against the expected order, then model the FIFO read
  task automatic tick(input bit rdy, input bit ab, input bit st);
    bit acc;
    logic [W-1:0] e;
    m_ready = rdy; abort = ab; start = st;
    empty_flag = force_empty || fifo_q.size() == 0;
    #1;
    if (rst && stalled) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== held)
        $display("FAIL hold: m_valid=%b m_data=%h required 1/%h", m_valid, m_data, held);
      else passes++;
    end
    if (m_valid === 1'b1 && m_ready) begin
      checks++;
      if (exp_q.size() == 0) $display("FAIL order: got unexpected word %h", m_data);
      else begin
        e = exp_q.pop_front();
        if (m_data !== e) $display("FAIL order: m_data=%h required %h", m_data, e);
        else passes++;
      end
      xfers++;
      if (first_x < 0) first_x = cyc;
      last_x = cyc;
    end
    stalled = rst && m_valid === 1'b1 && !m_ready;
    held = m_data;
    if (done === 1'b1) begin dones++; done_cyc = cyc; end
    if (empty_flag) begin
      checks++;
      if (rd_en !== 1'b0) $display("FAIL rd_empty: rd_en=%b required 0", rd_en);
      else passes++;
    end
    acc = rd_en === 1'b1 && !empty_flag;
    if (acc) begin
      accepted++;
      checks++;
      if (accepted - xfers > 2) $display("FAIL overread: outstanding=%0d required <=2", accepted - xfers);
      else passes++;
    end
    @(posedge clk); #1;
    cyc++;
    rdata = acc ? fifo_q.pop_front() : $urandom;
  endtask

  task automatic begin_burst(input int len, input int n, input bit seq);
    int eff;
    logic [W-1:0] w;
    eff = len == 0 ? 256 : len;
    fifo_q.delete(); exp_q.delete();
    for (int i = 0; i < n; i++) begin
      w = seq ? 32'hA0 + 32'(i) : $urandom;
      fifo_q.push_back(w);
      if (i < eff) exp_q.push_back(w);
    end
    accepted = 0; xfers = 0; dones = 0; done_cyc = -1; first_x = -1; last_x = -1;
    burst_len = L'(len);
    tick(1, 0, 1);
  endtask

  task automatic test_reset;
    fifo_q.push_back(32'h1234);
    burst_len = 8'd4;
    tick(1, 0, 1);
    tick(1, 0, 1);
    checks++; if (rd_en !== 1'b0) $display("FAIL rst_rd_en: %b required 0", rd_en); else passes++;
    checks++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid: %b required 0", m_valid); else passes++;
    checks++; if (m_data !== '0) $display("FAIL rst_m_data: %h required 0", m_data); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: %b required 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL rst_done: %b required 0", done); else passes++;
    checks++; if (aborted !== 1'b0) $display("FAIL rst_aborted: %b required 0", aborted); else passes++;
    checks++; if (word_count !== '0) $display("FAIL rst_wc: %0d required 0", word_count); else passes++;
    fifo_q.delete();
    rst = 1'b1;
    tick(1, 0, 0);
    checks++; if (busy !== 1'b0) $display("FAIL rst_start_ignored: busy=%b required 0", busy); else passes++;
  endtask

  task automatic test_basic;
    begin_burst(4, 4, 1);
    for (int i = 0; i < 30 && dones == 0; i++) tick(1, 0, 0);
    repeat (3) tick(1, 0, 0);
    checks++; if (dones != 1) $display("FAIL basic_done: pulses=%0d required 1", dones); else passes++;
    checks++; if (xfers != 4) $display("FAIL basic_xfers: %0d required 4", xfers); else passes++;
    checks++; if (last_x - first_x != 3) $display("FAIL basic_rate: span=%0d required 3", last_x - first_x); else passes++;
    checks++; if (done_cyc != last_x + 1) $display("FAIL basic_done_lat: cyc=%0d required %0d", done_cyc, last_x + 1); else passes++;
    checks++; if (word_count !== 8'd4) $display("FAIL basic_wc: %0d required 4", word_count); else passes++;
    checks++; if (aborted !== 1'b0) $display("FAIL basic_aborted: %b required 0", aborted); else passes++;
  endtask

  task automatic test_backpressure;
    begin_burst(3, 5, 0);
    for (int i = 0; i < 40 && dones == 0; i++) tick(i % 2 == 0, 0, 0);
    repeat (3) tick(1, 0, 0);
    checks++; if (dones != 1) $display("FAIL bp_done: pulses=%0d required 1", dones); else passes++;
    checks++; if (xfers != 3) $display("FAIL bp_xfers: %0d required 3", xfers); else passes++;
    checks++; if (word_count !== 8'd3) $display("FAIL bp_wc: %0d required 3", word_count); else passes++;
    checks++; if (fifo_q.size() != 2) $display("FAIL bp_left: %0d words left required 2", fifo_q.size()); else passes++;
  endtask

  task automatic test_empty_stall;
    int st_n;
    st_n = 0;
    begin_burst(6, 6, 0);
    for (int i = 0; i < 60 && dones == 0; i++) begin
      force_empty = accepted >= 2 && st_n < 5;
      if (force_empty) st_n++;
      tick(1, 0, 0);
    end
    force_empty = 0;
    repeat (3) tick(1, 0, 0);
    checks++; if (dones != 1) $display("FAIL stall_done: pulses=%0d required 1", dones); else passes++;
    checks++; if (xfers != 6) $display("FAIL stall_xfers: %0d required 6", xfers); else passes++;
    checks++; if (word_count !== 8'd6) $display("FAIL stall_wc: %0d required 6", word_count); else passes++;
  endtask

  task automatic test_abort;
    bit sent;
    sent = 0;
    begin_burst(8, 10, 0);
    for (int i = 0; i < 60 && dones == 0; i++) begin
      tick(1, accepted == 3 && !sent, 0);
      if (accepted == 3 && m_ready && abort) sent = 1;
    end
    repeat (3) tick(1, 1, 0);
    checks++; if (dones != 1) $display("FAIL abort_done: pulses=%0d required 1", dones); else passes++;
    checks++; if (xfers != 3) $display("FAIL abort_xfers: %0d required 3", xfers); else passes++;
    checks++; if (aborted !== 1'b1) $display("FAIL abort_flag: %b required 1", aborted); else passes++;
    checks++; if (word_count !== 8'd3) $display("FAIL abort_wc: %0d required 3", word_count); else passes++;
    checks++; if (fifo_q.size() != 7) $display("FAIL abort_left: %0d words left required 7", fifo_q.size()); else passes++;
  endtask

  task automatic test_reset_mid;
    begin_burst(8, 8, 0);
    for (int i = 0; i < 10 && m_valid !== 1'b1; i++) tick(0, 0, 0);
    checks++; if (m_valid !== 1'b1) $display("FAIL mid_setup: m_valid=%b required 1", m_valid); else passes++;
    rst = 1'b0;
    #1;
    checks++; if (rd_en !== 1'b0) $display("FAIL mid_rd_en: %b required 0", rd_en); else passes++;
    tick(0, 0, 0);
    checks++; if (m_valid !== 1'b0) $display("FAIL mid_m_valid: %b required 0", m_valid); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL mid_busy: %b required 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL mid_done: %b required 0", done); else passes++;
    rst = 1'b1;
    begin_burst(2, 2, 0);
    for (int i = 0; i < 30 && dones == 0; i++) tick(1, 0, 0);
    checks++; if (dones != 1 || xfers != 2) $display("FAIL mid_reburst: dones=%0d xfers=%0d required 1/2", dones, xfers); else passes++;
    checks++; if (word_count !== 8'd2) $display("FAIL mid_wc: %0d required 2", word_count); else passes++;
  endtask

  task automatic test_random;
    int len;
    for (int b = 0; b < 6; b++) begin
      len = $urandom_range(1, 20);
      begin_burst(len, len + $urandom_range(0, 3), 0);
      for (int i = 0; i < 400 && dones == 0; i++) begin
        force_empty = $urandom_range(0, 3) == 0;
        tick($urandom_range(0, 2) != 0, 0, 0);
      end
      force_empty = 0;
      checks++; if (dones != 1 || xfers != len) $display("FAIL rand_burst: dones=%0d xfers=%0d required 1/%0d", dones, xfers, len); else passes++;
      checks++; if (word_count !== L'(len)) $display("FAIL rand_wc: %0d required %0d", word_count, len); else passes++;
    end
  endtask

  task automatic test_len0;
    begin_burst(0, 256, 0);
    for (int i = 0; i < 2000 && dones == 0; i++) tick($urandom_range(0, 3) != 0, 0, 0);
    repeat (3) tick(1, 0, 0);
    checks++; if (dones != 1) $display("FAIL len0_done: pulses=%0d required 1", dones); else passes++;
    checks++; if (xfers != 256) $display("FAIL len0_xfers: %0d required 256", xfers); else passes++;
    checks++; if (word_count !== 8'd0) $display("FAIL len0_wc: %0d required 0", word_count); else passes++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_empty_stall;
    test_abort;
    test_reset_mid;
    test_random;
    test_len0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
